// File: rtl/zbt_pattern_writer_if.sv
// Write-port bundle between zbt_pattern_writer and the ZBT arbiter / start source.
// The checksum signal exists only when ZPW_CHECKSUM_EN is defined.
interface zbt_pattern_writer_if #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned ADDR_W = 19
);
  logic              start;
  logic              mem_grant;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
`ifdef ZPW_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, mem_grant,
    output busy, done, mem_we, mem_addr, mem_data, checksum
  );
  modport slave (
    output start, mem_grant,
    input  busy, done, mem_we, mem_addr, mem_data, checksum
  );
`else
  modport master (
    input  start, mem_grant,
    output busy, done, mem_we, mem_addr, mem_data
  );
  modport slave (
    output start, mem_grant,
    input  busy, done, mem_we, mem_addr, mem_data
  );
`endif
endinterface

// File: rtl/zbt_pattern_writer.sv
// Writes NUM_POINTS {pad, x, y, color} records to ZBT SRAM through a request/grant port.
// Optional ZPW_CHECKSUM_EN adds a running XOR of all accepted words in the run.
module zbt_pattern_writer #(
  parameter int unsigned       NUM_POINTS = 8,
  parameter int unsigned       COORD_W    = 10,
  parameter int unsigned       COLOR_W    = 10,
  parameter int unsigned       DATA_W     = 36,
  parameter int unsigned       ADDR_W     = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       X_START    = 100,
  parameter int unsigned       Y_START    = 100,
  parameter int unsigned       X_STEP     = 100,
  parameter int unsigned       Y_STEP     = 100,
  parameter logic [COLOR_W-1:0] COLOR_A   = 10'h3FC,
  parameter logic [COLOR_W-1:0] COLOR_B   = 10'h0FC
) (
  input logic clk,
  input logic reset,
  zbt_pattern_writer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  csum_q, csum_d;

  // Pad bits are the zero-extended MSBs of the packed record.
  function automatic logic [DATA_W-1:0] pack(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y,
                                             input logic odd);
    return DATA_W'({x, y, (odd ? COLOR_B : COLOR_A)});
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WRITE;
          idx_d   = '0;
          x_d     = COORD_W'(X_START);
          y_d     = COORD_W'(Y_START);
          addr_d  = BASE_ADDR;
          data_d  = pack(COORD_W'(X_START), COORD_W'(Y_START), 1'b0);
          we_d    = 1'b1;
          busy_d  = 1'b1;
          csum_d  = '0;
        end
      end
      WRITE: begin
        if (bus.mem_grant) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            x_d    = x_q + COORD_W'(X_STEP);
            y_d    = y_q + COORD_W'(Y_STEP);
            addr_d = addr_q + 1'b1;
            data_d = pack(x_d, y_d, idx_d[0]);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
`ifdef ZPW_CHECKSUM_EN
  assign bus.checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule
